// File: rtl/ddr_pg_pkg.sv
// Shared types and constants for the DDR pin-stress pattern generator.
// Covers FSM states, data pattern modes, the PRBS polynomial and command encodings.
package ddr_pg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_PRE,
    ST_DATA,
    ST_POST,
    ST_GAP,
    ST_DONE
  } pg_state_e;

  localparam logic [1:0] PG_CNT  = 2'd0;
  localparam logic [1:0] PG_WALK = 2'd1;
  localparam logic [1:0] PG_PRBS = 2'd2;
  localparam logic [1:0] PG_ALT  = 2'd3;

  // Right-shifting Galois form of x^32+x^22+x^2+x+1
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef struct packed {
    logic cs_n;
    logic ras_n;
    logic cas_n;
    logic we_n;
  } ddr_cmd_t;

  localparam ddr_cmd_t CMD_NOP   = 4'b1111;
  localparam ddr_cmd_t CMD_WRITE = 4'b0100;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
  endfunction

endpackage

// File: rtl/ddr_pg_lfsr32.sv
// 32-bit Galois PRBS that advances two beats per cycle, exposing the
// values for the even (d0) and odd (d1) beat of the current cycle.
module ddr_pg_lfsr32
  import ddr_pg_pkg::*;
#(
  parameter int          TAP_W = 16,
  parameter logic [31:0] SEED  = 32'hACE1_2345
) (
  input  logic             SYS_CLK,
  input  logic             RESET_N,
  input  logic             load,
  input  logic             advance,
  output logic [TAP_W-1:0] tap0,
  output logic [TAP_W-1:0] tap1
);

  logic [31:0] lfsr;
  logic [31:0] lfsr_odd;

  assign lfsr_odd = lfsr_step(lfsr);
  assign tap0     = lfsr[TAP_W-1:0];
  assign tap1     = lfsr_odd[TAP_W-1:0];

  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      lfsr <= SEED;
    end else if (load) begin
      lfsr <= SEED;
    end else if (advance) begin
      lfsr <= lfsr_step(lfsr_odd);
    end
  end

endmodule

// File: rtl/ddr_phy_pattern_gen.sv
// DDR write-burst pattern generator feeding ODDRX1F output stages.
// All outputs are registered from the next state so they line up with it.
module ddr_phy_pattern_gen
  import ddr_pg_pkg::*;
#(
  parameter int          DQ_WIDTH   = 16,
  parameter int          DQS_WIDTH  = 2,
  parameter int          ADDR_WIDTH = 16,
  parameter int          BA_WIDTH   = 3,
  parameter int          BURST_LEN  = 8,
  parameter int          GAP_CYCLES = 4,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_2345
) (
  input  logic                  SYS_CLK,
  input  logic                  RESET_N,
  input  logic                  start,
  input  logic                  stop,
  input  logic [1:0]            mode,
  input  logic [15:0]           burst_count,
  input  logic [DQ_WIDTH-1:0]   lane_en,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           bursts_done,
  output logic                  cs_n,
  output logic                  ras_n,
  output logic                  cas_n,
  output logic                  we_n,
  output logic [BA_WIDTH-1:0]   ba,
  output logic [ADDR_WIDTH-1:0] a,
  output logic [DQ_WIDTH-1:0]   dq_d0,
  output logic [DQ_WIDTH-1:0]   dq_d1,
  output logic                  dq_oe,
  output logic [DQS_WIDTH-1:0]  dqs_d0,
  output logic [DQS_WIDTH-1:0]  dqs_d1,
  output logic                  dqs_oe,
  output logic [DQS_WIDTH-1:0]  dm_d0,
  output logic [DQS_WIDTH-1:0]  dm_d1
);

  localparam logic [15:0] DATA_LAST = 16'(BURST_LEN / 2 - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

  pg_state_e state, state_nxt;
  logic [15:0]          cnt;
  logic [31:0]          beat;
  logic [1:0]           mode_q;
  logic [DQ_WIDTH-1:0]  lane_q;
  logic [15:0]          count_q;
  logic                 stop_lat;
  logic                 start_acc;
  logic                 stop_pend;
  logic                 last_burst;
  logic [15:0]          burst_idx;
  logic [31:0]          addr_ext;
  logic [DQ_WIDTH-1:0]  prbs0, prbs1;
  logic [DQS_WIDTH-1:0] dm_val;
  ddr_cmd_t             cmd_nxt;

  function automatic logic [DQ_WIDTH-1:0] pattern(input logic [1:0] m,
                                                  input logic [31:0] b,
                                                  input logic [DQ_WIDTH-1:0] prbs,
                                                  input logic odd);
    case (m)
      PG_CNT:  return b[DQ_WIDTH-1:0];
      PG_WALK: return {{(DQ_WIDTH-1){1'b0}}, 1'b1} << (b % 32'(DQ_WIDTH));
      PG_PRBS: return prbs;
      default: return odd ? {DQS_WIDTH{8'hAA}} : {DQS_WIDTH{8'h55}};
    endcase
  endfunction

  assign start_acc  = (state == ST_IDLE) && start;
  assign stop_pend  = stop_lat || stop;
  assign last_burst = (count_q != 16'd0) && (bursts_done + 16'd1 == count_q);
  assign burst_idx  = start_acc ? 16'd0 : bursts_done;
  assign addr_ext   = {16'd0, burst_idx} >> BA_WIDTH;
  assign cmd_nxt    = (state_nxt == ST_CMD) ? CMD_WRITE : CMD_NOP;

  always_comb begin
    dm_val = '0;
    for (int i = 0; i < DQS_WIDTH; i++) begin
      dm_val[i] = ~|lane_q[8*i +: 8];
    end
  end

  ddr_pg_lfsr32 #(
    .TAP_W (DQ_WIDTH),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .SYS_CLK (SYS_CLK),
    .RESET_N (RESET_N),
    .load    (start_acc),
    .advance (state_nxt == ST_DATA),
    .tap0    (prbs0),
    .tap1    (prbs1)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_CMD;
      ST_CMD:  state_nxt = ST_PRE;
      ST_PRE:  state_nxt = ST_DATA;
      ST_DATA: if (cnt == DATA_LAST) state_nxt = ST_POST;
      ST_POST: state_nxt = (last_burst || stop_pend) ? ST_DONE : ST_GAP;
      ST_GAP: begin
        if (stop_pend)            state_nxt = ST_DONE;
        else if (cnt == GAP_LAST) state_nxt = ST_CMD;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control: state, phase counter, stop latch, beat index, burst counter
  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      stop_lat    <= 1'b0;
      beat        <= '0;
      bursts_done <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? 16'd0 : cnt + 16'd1;
      busy  <= state_nxt inside {ST_CMD, ST_PRE, ST_DATA, ST_POST, ST_GAP};
      done  <= (state_nxt == ST_DONE);
      if (state_nxt == ST_IDLE)
        stop_lat <= 1'b0;
      else if (stop && (state inside {ST_CMD, ST_PRE, ST_DATA, ST_POST, ST_GAP}))
        stop_lat <= 1'b1;
      if (start_acc)
        beat <= '0;
      else if (state_nxt == ST_DATA)
        beat <= beat + 32'd2;
      if (start_acc)
        bursts_done <= '0;
      else if (state == ST_POST)
        bursts_done <= bursts_done + 16'd1;
    end
  end

  // Configuration is sampled once per accepted start
  always_ff @(posedge SYS_CLK) begin
    if (start_acc) begin
      mode_q  <= mode;
      lane_q  <= lane_en;
      count_q <= burst_count;
    end
  end

  // Pin stage: command, address and ODDR data/enables
  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      {cs_n, ras_n, cas_n, we_n} <= CMD_NOP;
      ba     <= '0;
      a      <= '0;
      dq_d0  <= '0;
      dq_d1  <= '0;
      dq_oe  <= 1'b0;
      dqs_d0 <= '0;
      dqs_d1 <= '0;
      dqs_oe <= 1'b0;
      dm_d0  <= '0;
      dm_d1  <= '0;
    end else begin
      {cs_n, ras_n, cas_n, we_n} <= cmd_nxt;
      if (state_nxt == ST_CMD) begin
        ba <= burst_idx[BA_WIDTH-1:0];
        a  <= addr_ext[ADDR_WIDTH-1:0];
      end
      dq_oe  <= (state_nxt == ST_DATA);
      dqs_oe <= state_nxt inside {ST_PRE, ST_DATA, ST_POST};
      dqs_d0 <= (state_nxt == ST_DATA) ? {DQS_WIDTH{1'b1}} : '0;
      dqs_d1 <= '0;
      if (state_nxt == ST_DATA) begin
        dq_d0 <= pattern(mode_q, beat, prbs0, 1'b0) & lane_q;
        dq_d1 <= pattern(mode_q, beat + 32'd1, prbs1, 1'b1) & lane_q;
        dm_d0 <= dm_val;
        dm_d1 <= dm_val;
      end else begin
        dq_d0 <= '0;
        dq_d1 <= '0;
        dm_d0 <= '0;
        dm_d1 <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ddr_phy_pattern_gen.sv
// Bench for ddr_phy_pattern_gen: each run's full pin trace is predicted by a
// burst-level sequence model and compared cycle by cycle.
module tb_ddr_phy_pattern_gen;

  logic        SYS_CLK;
  logic        RESET_N;
  logic        start, stop;
  logic [1:0]  mode;
  logic [15:0] burst_count;
  logic [15:0] lane_en;
  logic        busy, done;
  logic [15:0] bursts_done;
  logic        cs_n, ras_n, cas_n, we_n;
  logic [2:0]  ba;
  logic [15:0] a;
  logic [15:0] dq_d0, dq_d1;
  logic        dq_oe, dqs_oe;
  logic [1:0]  dqs_d0, dqs_d1, dm_d0, dm_d1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        busy;
    logic        done;
    logic [15:0] bd;
    logic [3:0]  cmd;
    logic [2:0]  ba;
    logic [15:0] a;
    logic        dq_oe;
    logic        dqs_oe;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  dqs0;
    logic [1:0]  dm;
    int          first_of;
  } rec_t;

  rec_t        exp_q[$];
  int          stop_idx;
  logic [15:0] first_d0[8];
  logic [15:0] first_d1[8];

  ddr_phy_pattern_gen dut (
    .SYS_CLK     (SYS_CLK),
    .RESET_N     (RESET_N),
    .start       (start),
    .stop        (stop),
    .mode        (mode),
    .burst_count (burst_count),
    .lane_en     (lane_en),
    .busy        (busy),
    .done        (done),
    .bursts_done (bursts_done),
    .cs_n        (cs_n),
    .ras_n       (ras_n),
    .cas_n       (cas_n),
    .we_n        (we_n),
    .ba          (ba),
    .a           (a),
    .dq_d0       (dq_d0),
    .dq_d1       (dq_d1),
    .dq_oe       (dq_oe),
    .dqs_d0      (dqs_d0),
    .dqs_d1      (dqs_d1),
    .dqs_oe      (dqs_oe),
    .dm_d0       (dm_d0),
    .dm_d1       (dm_d1)
  );

  initial SYS_CLK = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;

  task automatic chk(input string tag, input int idx, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, got, exp);
    end
  endtask

  // PRBS polynomial x^32+x^22+x^2+x+1, shifted towards bit 0
  function automatic logic [31:0] m_step(input logic [31:0] v);
    logic [31:0] taps;
    taps = (32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1;
    return v[0] ? ((v >> 1) ^ taps) : (v >> 1);
  endfunction

  function automatic logic [15:0] m_pat(input logic [1:0] m, input logic [31:0] b,
                                        input logic [31:0] lf, input bit odd);
    case (m)
      2'd0:    return b[15:0];
      2'd1:    return 16'd1 << (b % 16);
      2'd2:    return lf[15:0];
      default: return odd ? 16'hAAAA : 16'h5555;
    endcase
  endfunction

  function automatic rec_t mk(input logic bz, input logic dn, input int bd,
                              input logic [15:0] ah, input logic [2:0] bah);
    rec_t r;
    r.busy = bz;  r.done = dn;  r.bd = 16'(bd);
    r.cmd = 4'b1111;  r.ba = bah;  r.a = ah;
    r.dq_oe = 1'b0;  r.dqs_oe = 1'b0;
    r.d0 = '0;  r.d1 = '0;  r.dqs0 = '0;  r.dm = '0;
    r.first_of = -1;
    return r;
  endfunction

  // Expected trace from the first cycle after start to the idle cycle after DONE
  task automatic build(input logic [1:0] m, input logic [15:0] ln,
                       input logic [15:0] cnt, input int stop_burst);
    logic [31:0] b;
    logic [31:0] lf;
    logic [15:0] ah;
    logic [2:0]  bah;
    rec_t        r;
    b = 0;  lf = 32'hACE1_2345;
    exp_q.delete();
    stop_idx = -1;
    for (int j = 0; j < 64; j++) begin
      bah = 3'(j % 8);
      ah  = 16'(j / 8);
      r = mk(1, 0, j, ah, bah);  r.cmd = 4'b0100;  exp_q.push_back(r);
      r = mk(1, 0, j, ah, bah);  r.dqs_oe = 1;     exp_q.push_back(r);
      for (int k = 0; k < 4; k++) begin
        r = mk(1, 0, j, ah, bah);
        r.dq_oe = 1;  r.dqs_oe = 1;  r.dqs0 = 2'b11;
        r.d0 = m_pat(m, b, lf, 0) & ln;      lf = m_step(lf);
        r.d1 = m_pat(m, b + 1, lf, 1) & ln;  lf = m_step(lf);
        b = b + 2;
        r.dm = {~|ln[15:8], ~|ln[7:0]};
        if (k == 0) r.first_of = j;
        exp_q.push_back(r);
        if (j == stop_burst && k == 0) stop_idx = exp_q.size() - 1;
      end
      r = mk(1, 0, j, ah, bah);  r.dqs_oe = 1;  exp_q.push_back(r);
      if ((cnt != 0 && j + 1 == int'(cnt)) || j == stop_burst) begin
        exp_q.push_back(mk(0, 1, j + 1, ah, bah));
        exp_q.push_back(mk(0, 0, j + 1, ah, bah));
        break;
      end
      repeat (4) exp_q.push_back(mk(1, 0, j + 1, ah, bah));
    end
  endtask

  task automatic check_rec(input string tag, input int i, input rec_t e);
    chk({tag, ".busy"},   i, 64'(busy),   64'(e.busy));
    chk({tag, ".done"},   i, 64'(done),   64'(e.done));
    chk({tag, ".bursts"}, i, 64'(bursts_done), 64'(e.bd));
    chk({tag, ".cmd"},    i, 64'({cs_n, ras_n, cas_n, we_n}), 64'(e.cmd));
    chk({tag, ".ba"},     i, 64'(ba),     64'(e.ba));
    chk({tag, ".a"},      i, 64'(a),      64'(e.a));
    chk({tag, ".dq_oe"},  i, 64'(dq_oe),  64'(e.dq_oe));
    chk({tag, ".dqs_oe"}, i, 64'(dqs_oe), 64'(e.dqs_oe));
    chk({tag, ".dq_d0"},  i, 64'(dq_d0),  64'(e.d0));
    chk({tag, ".dq_d1"},  i, 64'(dq_d1),  64'(e.d1));
    chk({tag, ".dqs"},    i, 64'({dqs_d0, dqs_d1}), 64'({e.dqs0, 2'b00}));
    chk({tag, ".dm"},     i, 64'({dm_d0, dm_d1}),   64'({e.dm, e.dm}));
  endtask

  task automatic run_seq(input string tag, input logic [1:0] m, input logic [15:0] ln,
                         input logic [15:0] cnt, input int stop_burst, input int dup,
                         input bit stop_with_start);
    int dup_idx;
    build(m, ln, cnt, stop_burst);
    dup_idx = (dup >= 0) ? dup % (exp_q.size() - 1) : -1;
    for (int i = 0; i < 8; i++) begin
      first_d0[i] = 'x;
      first_d1[i] = 'x;
    end
    @(negedge SYS_CLK);
    mode = m;  lane_en = ln;  burst_count = cnt;
    start = 1;  stop = stop_with_start;
    @(negedge SYS_CLK);
    start = 0;  stop = 0;
    mode = 2'($urandom);  lane_en = 16'($urandom);  burst_count = 16'($urandom);
    for (int i = 0; i < exp_q.size(); i++) begin
      check_rec(tag, i, exp_q[i]);
      if (exp_q[i].first_of >= 0 && exp_q[i].first_of < 8) begin
        first_d0[exp_q[i].first_of] = dq_d0;
        first_d1[exp_q[i].first_of] = dq_d1;
      end
      stop  = (i == stop_idx);
      start = (i == dup_idx);
      @(negedge SYS_CLK);
    end
    start = 0;  stop = 0;
  endtask

  initial begin
    logic [1:0]  rm;
    logic [15:0] rl, rc;
    int          rs;
    RESET_N = 0;  start = 0;  stop = 0;
    mode = 0;  burst_count = 0;  lane_en = 0;
    #12;
    check_rec("reset", 0, mk(0, 0, 0, 16'd0, 3'd0));
    @(negedge SYS_CLK);
    RESET_N = 1;

    run_seq("cnt1", 2'd0, 16'hFFFF, 16'd1, -1, -1, 0);
    chk("cnt1_first_d0", 0, 64'(first_d0[0]), 64'h0);
    chk("cnt1_first_d1", 0, 64'(first_d1[0]), 64'h1);

    run_seq("walk", 2'd1, 16'hFFFF, 16'd0, 2, 5, 0);
    chk("walk_b2_d0", 1, 64'(first_d0[1]), 64'h0100);
    chk("walk_bursts", 0, 64'(bursts_done), 64'd3);

    run_seq("prbs", 2'd2, 16'hFFFF, 16'd2, -1, -1, 0);
    chk("prbs_first_d0", 0, 64'(first_d0[0]), 64'h2345);

    run_seq("mask", 2'd3, 16'h00FF, 16'd1, -1, -1, 0);
    chk("mask_d0", 0, 64'(first_d0[0]), 64'h0055);
    chk("mask_d1", 0, 64'(first_d1[0]), 64'h00AA);

    run_seq("startstop", 2'd0, 16'hFFFF, 16'd2, -1, -1, 1);
    chk("startstop_bursts", 0, 64'(bursts_done), 64'd2);

    for (int n = 0; n < 8; n++) begin
      rm = 2'($urandom);
      rl = ($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'($urandom);
      rc = 16'($urandom_range(0, 3));
      if (rc == 0) rs = $urandom_range(0, 2);
      else rs = ($urandom_range(0, 1) == 1) ? $urandom_range(0, int'(rc) - 1) : -1;
      run_seq($sformatf("rand%0d", n), rm, rl, rc, rs,
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 200)) : -1, 0);
    end

    // Asynchronous reset in the middle of a data burst
    @(negedge SYS_CLK);
    mode = 0;  lane_en = 16'hFFFF;  burst_count = 16'd2;  start = 1;
    @(negedge SYS_CLK);
    start = 0;
    repeat (3) @(negedge SYS_CLK);
    chk("mid_dq_oe", 0, 64'(dq_oe), 64'd1);
    #2 RESET_N = 0;
    #1;
    check_rec("midrst", 0, mk(0, 0, 0, 16'd0, 3'd0));
    @(negedge SYS_CLK);
    RESET_N = 1;
    run_seq("after_rst", 2'd0, 16'hFFFF, 16'd1, -1, -1, 0);
    chk("after_rst_d0", 0, 64'(first_d0[0]), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_phy_pattern_gen.md
Name: ddr_phy_pattern_gen

Overview:
Parametrised successor to the fixed-counter DDR pin-stress driver. It generates DDR-like write bursts for ODDRX1F-based output stages: a command, a DQS preamble, a data burst and a postamble, with DQ/DQS output enables. Data uses a selectable pattern (counter, walking-one, PRBS, max-toggle), with per-lane masking and a burst count. It sits between a test controller (start/stop handshake) and the ODDRX1F/BB instances for CK-domain pins. Every output is a registered D0/D1 pair or level.

Parameters:
DQ_WIDTH, 16, DQ bits; must equal 8*DQS_WIDTH; maximum 32
DQS_WIDTH, 2, byte lanes / strobes / DM bits
ADDR_WIDTH, 16, address pins
BA_WIDTH, 3, bank address pins
BURST_LEN, 8, beats per burst; even, at least 2; DATA lasts BURST_LEN/2 cycles
GAP_CYCLES, 4, idle cycles between bursts; at least 1
LFSR_SEED, 32'hACE12345, PRBS seed; must be nonzero

Ports:
SYS_CLK  in  1  fabric clock, same clock as the ODDRX1F SCLK
RESET_N  in  1  asynchronous active-low reset
start  in  1  one-cycle request, accepted only in IDLE
stop  in  1  request to finish the current burst, then return to IDLE
mode  in  2  0 counter, 1 walking-one, 2 PRBS, 3 alternating 0x55/0xAA
burst_count  in  16  number of bursts; 0 means continuous until stop
lane_en  in  DQ_WIDTH  per-bit enable; a disabled bit drives 0
busy  out  1  high from the cycle after start is accepted until the cycle done pulses
done  out  1  one-cycle pulse when the sequence ends
bursts_done  out  16  completed-burst counter; wraps
cs_n, ras_n, cas_n, we_n  out  1 each  command pins, level
ba  out  BA_WIDTH  bank address
a  out  ADDR_WIDTH  address
dq_d0, dq_d1  out  DQ_WIDTH  rising-edge and falling-edge data for the DQ ODDRs
dq_oe  out  1  DQ output enable; drives BB T=~dq_oe
dqs_d0, dqs_d1  out  DQS_WIDTH  strobe ODDR data
dqs_oe  out  1  DQS output enable
dm_d0, dm_d1  out  DQS_WIDTH  data mask ODDR data

Behaviour:
- Reset, asynchronous: state IDLE. busy=0, done=0, bursts_done=0. cs_n/ras_n/cas_n/we_n=1. a=0, ba=0. All d0/d1=0. dq_oe=0, dqs_oe=0. Beat index=0, LFSR=LFSR_SEED.
- Start acceptance: start in IDLE at cycle N captures mode, lane_en and burst_count; it also clears the beat index and bursts_done and reloads the LFSR. busy=1 and the first CMD appear at N+1. start outside IDLE is ignored.
- FSM: IDLE -> CMD (1 cycle) -> PRE (1) -> DATA (BURST_LEN/2) -> POST (1) -> GAP (GAP_CYCLES) -> CMD, or DONE (1) -> IDLE.
- Outside CMD, command pins are NOP: all four at 1.
- CMD: cs_n=0, ras_n=1, cas_n=0, we_n=0. ba=burst_idx[BA_WIDTH-1:0]. a=(burst_idx>>BA_WIDTH) zero-extended or truncated to ADDR_WIDTH. a and ba hold their value outside CMD.
- PRE: dqs_oe=1, dqs_d0=dqs_d1=0.
- DATA: dqs_oe=1, dqs_d0=all ones, dqs_d1=0. dq_oe=1. Data for beat 2k goes on d0 and beat 2k+1 on d1. The beat index advances by 2 per cycle.
- POST: dqs_oe=1, dqs 0/0, dq_oe=0. dq_d0/dq_d1 are 0 whenever not in DATA.
- Pattern for beat b (raw value before lane_en masking):
  - counter: b, replicated/truncated to DQ_WIDTH.
  - walking-one: 1 << (b mod DQ_WIDTH).
  - PRBS: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, stepped once per beat; output is the low DQ_WIDTH bits of the current value, before the step.
  - alternating: d0 = {..0x55}, d1 = {..0xAA}.
- The beat index and LFSR continue across bursts and are not reset per burst.
- Output data = raw & lane_en.
- DM: for lane i, dm_d0[i]=dm_d1[i]=~|lane_en[8i+7:8i] during DATA, else 0.
- POST exit: bursts_done increments. Go to DONE if (burst_count!=0 and bursts_done+1==burst_count) or stop is latched; else go to GAP.
- stop: latched on any busy cycle and cleared on IDLE entry. The current burst always completes, including POST; GAP is skipped. stop in IDLE has no effect.
- Simultaneous stop and start in IDLE: start is accepted, stop is ignored.
- DONE: done=1 for one cycle; busy falls in the same cycle.
- Reset mid-burst: outputs return to their reset values immediately; dq_oe and dqs_oe go to 0.
- Counters: the beat index is 32 bits and the burst index is 16 bits; both wrap silently.

Decomposition:
- Package ddr_pg_pkg:
  - state enum (IDLE, CMD, PRE, DATA, POST, GAP, DONE);
  - mode constants PG_CNT, PG_WALK, PG_PRBS, PG_ALT;
  - LFSR polynomial constant;
  - NOP and WRITE command encodings.
- Sub-module ddr_pg_lfsr32: seed load, two-step-per-cycle Galois LFSR, and the beat-2k and beat-2k+1 output taps.

Test Plan:
- Counter, single burst: mode=0, burst_count=1, lane_en=16'hFFFF, start at N.
  - CMD at N+1 with ba=0, a=0.
  - DATA at N+3..N+6 with d0/d1 = 0/1, 2/3, 4/5, 6/7.
  - POST at N+7; done at N+8; bursts_done=1.
- Walking-one, continuous: mode=1, burst_count=0, run 3 bursts, then stop during the 3rd DATA.
  - Burst 2 first d0 = 16'h0100.
  - The 3rd burst completes, with no GAP, then done; bursts_done=3.
  - The 2nd CMD has ba=1.
- PRBS: mode=2, 2 bursts.
  - First dq_d0=16'h2345.
  - The full sequence matches the reference-model LFSR from the seed and continues across the gap.
- Lane mask: mode=3, lane_en=16'h00FF.
  - dq_d0=16'h0055, dq_d1=16'h00AA.
  - dm_d0=dm_d1=2'b10 during DATA.
- Reset mid-DATA: deassert RESET_N asynchronously.
  - All oe=0, command pins at 1, busy=0 without a clock edge.
  - After release, start restarts at beat 0.
- Ignored requests:
  - start while busy: no effect on the sequence.
  - start+stop together in IDLE: runs the full burst_count=2 sequence.
  - GAP length is 4 cycles, measured between POST and the next CMD.
